// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch stage's start/branch/compare/halt inputs and its
//   program-counter and status outputs.
//   master : the side that drives start, branch decode and compare results
//            (control decoder / testbench) and observes the fetch outputs.
//   slave  : the fetch stage itself.
//   Signals:
//     start, start_addr                       restart handshake
//     conditional_jump, branch_abs_or_rel,
//     branch_conditions, target               branch decode + operand
//     flag_wr_en, cmp_zero, cmp_less          compare flag update
//     ack                                     halt instruction decoded
//     prog_ctr, running, done, cycle_count    fetch stage outputs
// ----------------------------------------------------------------------------
interface fetch_if #(
    parameter int PC_W   = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [PC_W-1:0]   start_addr;
    logic              conditional_jump;
    logic              branch_abs_or_rel;
    logic [1:0]        branch_conditions;
    logic [DATA_W-1:0] target;
    logic              flag_wr_en;
    logic              cmp_zero;
    logic              cmp_less;
    logic              ack;
    logic [PC_W-1:0]   prog_ctr;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output start, start_addr, conditional_jump, branch_abs_or_rel,
               branch_conditions, target, flag_wr_en, cmp_zero, cmp_less, ack,
        input  prog_ctr, running, done, cycle_count
    );

    modport slave (
        input  start, start_addr, conditional_jump, branch_abs_or_rel,
               branch_conditions, target, flag_wr_en, cmp_zero, cmp_less, ack,
        output prog_ctr, running, done, cycle_count
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Program counter / fetch stage for the 9-bit ISA. Sequences
//   IDLE -> LOAD -> RUN -> HALT under the start handshake, resolves
//   conditional branches (absolute or PC-relative) against the registered
//   compare flags, and counts RUN cycles (saturating) for benchmarking.
//   Ports:
//     clk      : system clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : fetch_if.slave (start, branch decode, compare flags, ack in;
//                prog_ctr, running, done, cycle_count out)
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W   = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic    clk,
    input  logic    reset_n,
    fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t           state_r;
    logic [PC_W-1:0]  pc_r;
    logic             z_r;
    logic             l_r;
    logic [CNT_W-1:0] cnt_r;

    logic             cond_s;
    logic [PC_W-1:0]  tgt_abs_s;
    logic [PC_W-1:0]  tgt_rel_s;
    logic [PC_W-1:0]  next_run_pc_s;

    // Branch condition from the flags as they stood before this cycle's CMP.
    always_comb begin
        cond_s = 1'b0;
        case (bus.branch_conditions)
            2'b00:   cond_s = 1'b1;
            2'b01:   cond_s = z_r;
            2'b10:   cond_s = l_r;
            2'b11:   cond_s = (~z_r) & (~l_r);
            default: cond_s = 1'b0;
        endcase
    end

    // Absolute target is zero-extended; relative offset is sign-extended and
    // the PC_W-bit add wraps naturally in both directions.
    assign tgt_abs_s = PC_W'(bus.target);
    assign tgt_rel_s = pc_r + PC_W'($signed(bus.target));

    // Next PC while running (ack handled separately: it freezes the PC).
    always_comb begin
        next_run_pc_s = pc_r + PC_W'(1);
        if (bus.conditional_jump && cond_s) begin
            if (bus.branch_abs_or_rel) begin
                next_run_pc_s = tgt_rel_s;
            end else begin
                next_run_pc_s = tgt_abs_s;
            end
        end else begin
            next_run_pc_s = pc_r + PC_W'(1);
        end
    end

    // Control FSM with PC, compare flags and cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            pc_r    <= {PC_W{1'b0}};
            z_r     <= 1'b0;
            l_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (bus.start) begin
            // Start wins in every state, including an abort mid-run.
            state_r <= LOAD;
            pc_r    <= bus.start_addr;
            z_r     <= 1'b0;
            l_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: state_r <= IDLE;
                LOAD: state_r <= RUN;   // PC still at start_addr: fetched first
                RUN: begin
                    if (cnt_r != {CNT_W{1'b1}}) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                    // The all-ones halt encoding also raises conditional_jump,
                    // so ack must take priority and leave the PC on the halt.
                    if (bus.ack) begin
                        state_r <= HALT;
                    end else begin
                        pc_r <= next_run_pc_s;
                    end
                    if (bus.flag_wr_en) begin
                        z_r <= bus.cmp_zero;
                        l_r <= bus.cmp_less;
                    end
                end
                HALT:    state_r <= HALT;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.prog_ctr    = pc_r;
    assign bus.running     = (state_r == RUN);
    assign bus.done        = (state_r == HALT);
    assign bus.cycle_count = cnt_r;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model advances with the
//   stimulus each cycle and pushes the expected outputs into a queue; after
//   the clock edge the entry is popped and compared with the DUT.
// ----------------------------------------------------------------------------
module tb_fetch_unit;
    localparam int PC_W   = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fetch_if #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string tag;
        int    pc;
        int    running;
        int    done;
        int    cnt;
    } exp_t;

    exp_t sb_q[$];

    // Model state: 0 idle, 1 load, 2 run, 3 halt
    int m_st, m_pc, m_z, m_l, m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit cond_true(input int bc);
        case (bc)
            0:       return 1'b1;
            1:       return m_z != 0;
            2:       return m_l != 0;
            default: return (m_z == 0) && (m_l == 0);
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_pc = 0; m_z = 0; m_l = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int t;
        if (bus.start) begin
            m_st = 1; m_pc = int'(bus.start_addr); m_z = 0; m_l = 0; m_cnt = 0;
        end else if (m_st == 1) begin
            m_st = 2;
        end else if (m_st == 2) begin
            if (m_cnt < 65535) m_cnt++;
            if (bus.ack) begin
                m_st = 3;
            end else if (bus.conditional_jump && cond_true(int'(bus.branch_conditions))) begin
                if (!bus.branch_abs_or_rel) begin
                    m_pc = int'(bus.target);
                end else begin
                    t = int'(bus.target);
                    if (t >= 128) t -= 256;
                    m_pc = (m_pc + t + 1024) % 1024;
                end
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
            if (bus.flag_wr_en) begin
                m_z = bus.cmp_zero ? 1 : 0;
                m_l = bus.cmp_less ? 1 : 0;
            end
        end
    endtask

    task automatic clear_in();
        bus.start = 1'b0; bus.start_addr = '0; bus.conditional_jump = 1'b0;
        bus.branch_abs_or_rel = 1'b0; bus.branch_conditions = 2'b00;
        bus.target = '0; bus.flag_wr_en = 1'b0; bus.cmp_zero = 1'b0;
        bus.cmp_less = 1'b0; bus.ack = 1'b0;
    endtask

    // One clock: predict, push, clock, pop, compare.
    task automatic cycle(input string tag);
        exp_t e;
        model_step();
        sb_q.push_back(exp_t'{tag, m_pc, (m_st == 2) ? 1 : 0, (m_st == 3) ? 1 : 0, m_cnt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".pc"},   32'(bus.prog_ctr),    32'(e.pc));
        check({e.tag, ".run"},  32'(bus.running),     32'(e.running));
        check({e.tag, ".done"}, 32'(bus.done),        32'(e.done));
        check({e.tag, ".cnt"},  32'(bus.cycle_count), 32'(e.cnt));
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic branch(input bit rel, input logic [1:0] bc, input logic [7:0] tgt);
        bus.conditional_jump = 1'b1; bus.branch_abs_or_rel = rel;
        bus.branch_conditions = bc; bus.target = tgt;
    endtask

    task automatic restart(input int addr);
        clear_in();
        bus.start = 1'b1; bus.start_addr = PC_W'(addr);
        cycle("load");
        bus.start = 1'b0;
        cycle("enter_run");
    endtask

    initial begin
        reset_n = 1'b0;
        clear_in();
        model_reset();
        #12;
        check("rst.pc",   32'(bus.prog_ctr),    32'd0);
        check("rst.run",  32'(bus.running),     32'd0);
        check("rst.done", 32'(bus.done),        32'd0);
        check("rst.cnt",  32'(bus.cycle_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        cycle("idle_hold");

        // Start held two cycles at 100, then released
        bus.start = 1'b1; bus.start_addr = 10'd100;
        cycle("st1");
        check("st1.run0", 32'(bus.running), 32'd0);
        cycle("st2");
        bus.start = 1'b0;
        cycle("st3");
        check("st3.pc100", 32'(bus.prog_ctr), 32'd100);
        check("st3.run1",  32'(bus.running),  32'd1);
        cycle("st4");
        cycle("st5");
        check("st5.pc102", 32'(bus.prog_ctr), 32'd102);

        // Flags and relative branches
        restart(48);
        bus.flag_wr_en = 1'b1; bus.cmp_zero = 1'b1; bus.cmp_less = 1'b0;
        cycle("cmp_z");
        clear_in();
        cycle("to50");
        branch(1'b1, 2'b11, 8'hFC);
        cycle("gt_nt");
        check("gt_nt.pc51", 32'(bus.prog_ctr), 32'd51);
        branch(1'b0, 2'b00, 8'd50);
        cycle("abs50");
        branch(1'b1, 2'b01, 8'hFC);
        cycle("eq_rel");
        check("eq_rel.pc46", 32'(bus.prog_ctr), 32'd46);
        branch(1'b1, 2'b01, 8'h04);
        bus.flag_wr_en = 1'b1; bus.cmp_zero = 1'b0;
        cycle("old_flag");
        clear_in();
        branch(1'b1, 2'b01, 8'h04);
        cycle("new_flag");
        check("new_flag.pc51", 32'(bus.prog_ctr), 32'd51);

        // Absolute branch, PC wrap, relative wrap both ways
        restart(900);
        branch(1'b0, 2'b00, 8'hF0);
        cycle("abs240");
        check("abs240.pc", 32'(bus.prog_ctr), 32'd240);
        restart(1023);
        cycle("wrap0");
        check("wrap0.pc", 32'(bus.prog_ctr), 32'd0);
        branch(1'b1, 2'b00, 8'hFC);
        cycle("rel_dn");
        check("rel_dn.pc", 32'(bus.prog_ctr), 32'd1020);
        branch(1'b1, 2'b00, 8'h05);
        cycle("rel_up");
        check("rel_up.pc", 32'(bus.prog_ctr), 32'd1);

        // Halt: ack together with conditional_jump
        restart(1);
        for (int i = 0; i < 11; i++) cycle("run_to12");
        branch(1'b0, 2'b00, 8'hFF);
        bus.ack = 1'b1;
        cycle("ack");
        check("ack.pc12",  32'(bus.prog_ctr),    32'd12);
        check("ack.done",  32'(bus.done),        32'd1);
        check("ack.cnt12", 32'(bus.cycle_count), 32'd12);
        bus.ack = 1'b0; bus.flag_wr_en = 1'b1; bus.cmp_zero = 1'b1;
        for (int i = 0; i < 3; i++) cycle("halt_hold");

        // Start pulsed mid-run at PC=300 clears flags and counter
        restart(299);
        bus.flag_wr_en = 1'b1; bus.cmp_zero = 1'b1; bus.cmp_less = 1'b1;
        cycle("to300");
        clear_in();
        bus.start = 1'b1; bus.start_addr = 10'd5;
        cycle("abort");
        check("abort.pc5",  32'(bus.prog_ctr),    32'd5);
        check("abort.cnt0", 32'(bus.cycle_count), 32'd0);
        bus.start = 1'b0;
        cycle("abort_run");
        branch(1'b0, 2'b01, 8'h80);
        cycle("z_clr");
        check("z_clr.pc6", 32'(bus.prog_ctr), 32'd6);
        branch(1'b0, 2'b10, 8'h80);
        cycle("l_clr");
        branch(1'b0, 2'b11, 8'h80);
        cycle("gt_taken");
        check("gt_taken.pc128", 32'(bus.prog_ctr), 32'd128);

        // Async reset mid-run at PC=37
        restart(35);
        cycle("r36");
        cycle("r37");
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst.pc",   32'(bus.prog_ctr),    32'd0);
        check("mid_rst.run",  32'(bus.running),     32'd0);
        check("mid_rst.done", 32'(bus.done),        32'd0);
        check("mid_rst.cnt",  32'(bus.cycle_count), 32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        cycle("post_rst_idle");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            bus.start             = ($urandom_range(0, 24) == 0);
            bus.start_addr        = PC_W'($urandom_range(0, 1023));
            bus.conditional_jump  = 1'($urandom_range(0, 1));
            bus.branch_abs_or_rel = 1'($urandom_range(0, 1));
            bus.branch_conditions = 2'($urandom_range(0, 3));
            bus.target            = 8'($urandom_range(0, 255));
            bus.flag_wr_en        = 1'($urandom_range(0, 1));
            bus.cmp_zero          = 1'($urandom_range(0, 1));
            bus.cmp_less          = 1'($urandom_range(0, 1));
            bus.ack               = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end

        // Counter saturation
        restart(0);
        quiet(65540);
        check("sat.cnt_model", 32'(bus.cycle_count), 32'(m_cnt));
        check("sat.cnt_max",   32'(bus.cycle_count), 32'd65535);
        cycle("sat_hold");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
